// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter for the CPU's single unified instruction and
//               data memory. The CPU and an external port (program loader or
//               DMA) each have a req/ready handshake. Ties are resolved by
//               fixed CPU priority or by round-robin, selected by parameter.
//               One access is in flight at a time. Each access holds mem_en
//               for MEM_LATENCY cycles and is followed by a one-cycle ready
//               pulse to the winning requester.
//
// Parameters  : AW           - address width
//               DW           - data width
//               MEM_LATENCY  - cycles mem_en is held per access (>= 1)
//               CPU_PRIORITY - 1: CPU wins every tie; 0: round-robin
//
// Ports       : clk, reset                  - clock and async active-high reset
//               cpu_req/we/addr/wdata       - CPU request side
//               cpu_rdata, cpu_ready        - CPU read data and completion
//               ext_req/we/addr/wdata       - external request side
//               ext_rdata, ext_ready        - external read data and completion
//               mem_en/we/addr/wdata        - latched memory strobes and data
//               mem_rdata                   - memory read data (last BUSY cycle)
//               busy                        - high while an access is in flight
//               owner                       - current/last grant (0 CPU, 1 ext)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int                 c_CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_owner;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic [DW-1:0]      r_cpu_rdata;
    logic [DW-1:0]      r_ext_rdata;
    logic               r_cpu_ready;
    logic               r_ext_ready;

    logic               w_any_req;
    logic               w_grant_ext;
    logic               w_start;
    logic               w_last;

    assign w_any_req = cpu_req | ext_req;

    // External port wins when it is alone, or on a round-robin tie when the
    // CPU held the previous grant. With CPU priority the CPU takes every tie.
    assign w_grant_ext = ext_req & (~cpu_req | ((CPU_PRIORITY == 0) & ~r_owner));

    assign w_start = (r_state == c_ST_IDLE) & w_any_req;
    assign w_last  = (r_state == c_ST_BUSY) & (r_cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any_req) w_state_next = c_ST_BUSY;
            c_ST_BUSY: if (r_cnt == '0) w_state_next = c_ST_RESP;
            c_ST_RESP: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: grant latching, latency counter, read capture, ready pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_owner     <= 1'b1;   // makes the CPU the first round-robin winner
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_ext_ready <= 1'b0;
        end else begin
            // Ready is high only in the cycle after the last BUSY cycle.
            r_cpu_ready <= w_last & ~r_owner;
            r_ext_ready <= w_last & r_owner;

            if (w_start) begin
                r_owner     <= w_grant_ext;
                r_mem_addr  <= w_grant_ext ? ext_addr  : cpu_addr;
                r_mem_wdata <= w_grant_ext ? ext_wdata : cpu_wdata;
                r_mem_we    <= w_grant_ext ? ext_we    : cpu_we;
                r_mem_en    <= 1'b1;
                r_cnt       <= c_CNT_INIT;
            end else if (r_state == c_ST_BUSY) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    if (!r_mem_we) begin
                        if (r_owner) begin
                            r_ext_rdata <= mem_rdata;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                        end
                    end
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            end
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign ext_rdata = r_ext_rdata;
    assign cpu_ready = r_cpu_ready;
    assign ext_ready = r_ext_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != c_ST_IDLE);
    assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Two instances run side
//               by side: instance 0 with MEM_LATENCY=3 and round-robin,
//               instance 1 with MEM_LATENCY=1 and CPU priority. A transaction
//               timeline model predicts every output on every cycle; a table
//               of directed transactions, a few hand-written sequences and a
//               randomized phase drive the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_ready [2];
    logic        ext_req   [2];
    logic        ext_we    [2];
    logic [31:0] ext_addr  [2];
    logic [31:0] ext_wdata [2];
    logic [31:0] ext_rdata [2];
    logic        ext_ready [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
    logic        owner     [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_arbiter #(
            .AW          (32),
            .DW          (32),
            .MEM_LATENCY ((gi == 0) ? 3 : 1),
            .CPU_PRIORITY((gi == 0) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .cpu_req  (cpu_req[gi]),
            .cpu_we   (cpu_we[gi]),
            .cpu_addr (cpu_addr[gi]),
            .cpu_wdata(cpu_wdata[gi]),
            .cpu_rdata(cpu_rdata[gi]),
            .cpu_ready(cpu_ready[gi]),
            .ext_req  (ext_req[gi]),
            .ext_we   (ext_we[gi]),
            .ext_addr (ext_addr[gi]),
            .ext_wdata(ext_wdata[gi]),
            .ext_rdata(ext_rdata[gi]),
            .ext_ready(ext_ready[gi]),
            .mem_en   (mem_en[gi]),
            .mem_we   (mem_we[gi]),
            .mem_addr (mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_rdata(mem_rdata[gi]),
            .busy     (busy[gi]),
            .owner    (owner[gi])
        );
    end

    function automatic int lat(int m);
        return (m == 0) ? 3 : 1;
    endfunction

    function automatic bit prio(int m);
        return (m == 1);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int m, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, m, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction timeline model. A grant at the edge that starts cycle g
    // gives mem_en in cycles g..g+L-1, ready in cycle g+L and an idle
    // cycle g+L+1 where a new request may be seen.
    // ------------------------------------------------------------------
    int          cyc;
    bit          m_act [2];
    int          m_g   [2];
    bit          m_own [2];
    bit          m_we  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd  [2];
    logic [31:0] m_rd  [2][2];
    bit          e_en  [2];
    bit          e_crdy[2];
    bit          e_erdy[2];

    task automatic model_step();
        bit w;
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                m_act[m]   = 1'b0;
                m_own[m]   = 1'b1;
                m_we[m]    = 1'b0;
                m_addr[m]  = '0;
                m_wd[m]    = '0;
                m_rd[m][0] = '0;
                m_rd[m][1] = '0;
            end
        end else begin
            cyc++;
            for (int m = 0; m < 2; m++) begin
                if (m_act[m]) begin
                    if (cyc == m_g[m] + lat(m) && !m_we[m]) m_rd[m][m_own[m]] = mem_rdata[m];
                    if (cyc == m_g[m] + lat(m) + 1) m_act[m] = 1'b0;
                end else if (cpu_req[m] || ext_req[m]) begin
                    if (cpu_req[m] && ext_req[m]) w = prio(m) ? 1'b0 : !m_own[m];
                    else                          w = ext_req[m];
                    m_act[m]  = 1'b1;
                    m_g[m]    = cyc;
                    m_own[m]  = w;
                    m_we[m]   = w ? ext_we[m]    : cpu_we[m];
                    m_addr[m] = w ? ext_addr[m]  : cpu_addr[m];
                    m_wd[m]   = w ? ext_wdata[m] : cpu_wdata[m];
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            e_en[m]   = m_act[m] && (cyc - m_g[m] < lat(m));
            e_crdy[m] = m_act[m] && (cyc == m_g[m] + lat(m)) && !m_own[m];
            e_erdy[m] = m_act[m] && (cyc == m_g[m] + lat(m)) && m_own[m];
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk("busy",      m, {31'b0, busy[m]},      {31'b0, m_act[m]});
            chk("mem_en",    m, {31'b0, mem_en[m]},    {31'b0, e_en[m]});
            chk("mem_we",    m, {31'b0, mem_we[m]},    {31'b0, e_en[m] & m_we[m]});
            chk("mem_addr",  m, mem_addr[m],           m_addr[m]);
            chk("mem_wdata", m, mem_wdata[m],          m_wd[m]);
            chk("cpu_ready", m, {31'b0, cpu_ready[m]}, {31'b0, e_crdy[m]});
            chk("ext_ready", m, {31'b0, ext_ready[m]}, {31'b0, e_erdy[m]});
            chk("owner",     m, {31'b0, owner[m]},     {31'b0, m_own[m]});
            chk("cpu_rdata", m, cpu_rdata[m],          m_rd[m][0]);
            chk("ext_rdata", m, ext_rdata[m],          m_rd[m][1]);
        end
    endtask

    // One cycle: wait for the falling edge, advance the model over the
    // rising edge just passed, compare. Inputs change only after this.
    task automatic tick();
        @(negedge clk);
        model_step();
        check_all();
    endtask

    task automatic drop(int m);
        cpu_req[m] = 1'b0;
        ext_req[m] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed transaction table
    // ------------------------------------------------------------------
    typedef struct {
        int          dut;
        bit          creq;
        bit          cwe;
        logic [31:0] caddr;
        logic [31:0] cwd;
        bit          ereq;
        bit          ewe;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [31:0] mval;
        bit          exp_ext;
        logic [31:0] exp_crd;
        logic [31:0] exp_erd;
    } vec_t;

    vec_t tbl [11];

    task automatic apply(vec_t v);
        int          m;
        logic [31:0] ea;
        bit          ewr;
        m            = v.dut;
        cpu_req[m]   = v.creq;  cpu_we[m] = v.cwe;  cpu_addr[m] = v.caddr;  cpu_wdata[m] = v.cwd;
        ext_req[m]   = v.ereq;  ext_we[m] = v.ewe;  ext_addr[m] = v.eaddr;  ext_wdata[m] = v.ewd;
        mem_rdata[m] = v.mval;
        ea           = v.exp_ext ? v.eaddr : v.caddr;
        ewr          = v.exp_ext ? v.ewe   : v.cwe;
        for (int t = 1; t <= lat(m) + 1; t++) begin
            tick();
            if (t <= lat(m)) begin
                chk("tbl_mem_en",   m, {31'b0, mem_en[m]}, 32'd1);
                chk("tbl_mem_we",   m, {31'b0, mem_we[m]}, {31'b0, ewr});
                chk("tbl_mem_addr", m, mem_addr[m],        ea);
            end else begin
                chk("tbl_mem_en_off", m, {31'b0, mem_en[m]},    32'd0);
                chk("tbl_cpu_ready",  m, {31'b0, cpu_ready[m]}, {31'b0, !v.exp_ext});
                chk("tbl_ext_ready",  m, {31'b0, ext_ready[m]}, {31'b0, v.exp_ext});
                chk("tbl_owner",      m, {31'b0, owner[m]},     {31'b0, v.exp_ext});
                chk("tbl_cpu_rdata",  m, cpu_rdata[m],          v.exp_crd);
                chk("tbl_ext_rdata",  m, ext_rdata[m],          v.exp_erd);
            end
        end
        drop(m);
        tick();
    endtask

    bit hold [2][2];

    initial begin
        // dut 1: MEM_LATENCY=1, CPU priority.  dut 0: MEM_LATENCY=3, round-robin.
        tbl[0]  = '{1, 1, 0, 32'h40,  0, 0, 0, 0,      0,            32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
        tbl[1]  = '{0, 0, 0, 0,       0, 1, 1, 32'h100, 32'h12345678, 32'hAAAA5555, 1, 0,            0};
        tbl[2]  = '{0, 1, 0, 32'h10,  0, 1, 0, 32'h20,  0,            32'h11111111, 0, 32'h11111111, 0};
        tbl[3]  = '{0, 1, 0, 32'h10,  0, 1, 0, 32'h20,  0,            32'h22222222, 1, 32'h11111111, 32'h22222222};
        tbl[4]  = '{0, 1, 0, 32'h10,  0, 1, 0, 32'h20,  0,            32'h33333333, 0, 32'h33333333, 32'h22222222};
        tbl[5]  = '{0, 1, 0, 32'h10,  0, 1, 0, 32'h20,  0,            32'h44444444, 1, 32'h33333333, 32'h44444444};
        tbl[6]  = '{1, 1, 0, 32'h44,  0, 1, 0, 32'h88,  0,            32'h0A0A0A0A, 0, 32'h0A0A0A0A, 0};
        tbl[7]  = '{1, 1, 0, 32'h44,  0, 1, 0, 32'h88,  0,            32'h0B0B0B0B, 0, 32'h0B0B0B0B, 0};
        tbl[8]  = '{1, 1, 0, 32'h44,  0, 1, 0, 32'h88,  0,            32'h0C0C0C0C, 0, 32'h0C0C0C0C, 0};
        tbl[9]  = '{1, 0, 0, 0,       0, 1, 0, 32'h88,  0,            32'h5A5A5A5A, 1, 32'h0C0C0C0C, 32'h5A5A5A5A};
        tbl[10] = '{0, 1, 1, 32'h200, 32'hCAFEF00D, 0, 0, 0, 0,     32'h99999999, 0, 32'h33333333, 32'h44444444};

        cyc   = 0;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            cpu_req[m] = 0; cpu_we[m] = 0; cpu_addr[m] = 0; cpu_wdata[m] = 0;
            ext_req[m] = 0; ext_we[m] = 0; ext_addr[m] = 0; ext_wdata[m] = 0;
            mem_rdata[m] = 0;
            hold[m][0] = 0; hold[m][1] = 0;
        end
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) apply(tbl[i]);

        // Requester inputs changing during BUSY must not reach the memory.
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h40; mem_rdata[0] = 32'h76543210;
        tick();
        cpu_addr[0] = 32'h80; cpu_we[0] = 1; cpu_wdata[0] = 32'hFFFF0000;
        tick();
        chk("hold_addr", 0, mem_addr[0], 32'h40);
        chk("hold_we",   0, {31'b0, mem_we[0]}, 32'd0);
        tick();
        chk("hold_addr_end", 0, mem_addr[0], 32'h40);
        tick();
        chk("hold_ready", 0, {31'b0, cpu_ready[0]}, 32'd1);
        chk("hold_rdata", 0, cpu_rdata[0], 32'h76543210);
        drop(0);
        tick();

        // Reset in the middle of BUSY aborts the access with no ready.
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'hC0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("abort_mem_en", 0, {31'b0, mem_en[0]}, 32'd0);
        chk("abort_busy",   0, {31'b0, busy[0]},   32'd0);
        chk("abort_owner",  0, {31'b0, owner[0]},  32'd1);
        drop(0);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_no_ready", 0, {31'b0, cpu_ready[0]}, 32'd0);
        tick();
        chk("abort_no_ready2", 0, {31'b0, cpu_ready[0]}, 32'd0);
        cpu_req[0] = 1; ext_req[0] = 1; cpu_we[0] = 0; ext_we[0] = 0;
        for (int t = 1; t <= 4; t++) tick();
        chk("post_reset_cpu_ready", 0, {31'b0, cpu_ready[0]}, 32'd1);
        chk("post_reset_ext_ready", 0, {31'b0, ext_ready[0]}, 32'd0);
        chk("post_reset_owner",     0, {31'b0, owner[0]},     32'd0);
        drop(0);
        tick();

        // Randomized requesters following the handshake on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (e_crdy[m]) hold[m][0] = 0;
                if (e_erdy[m]) hold[m][1] = 0;
                if (hold[m][0] && $urandom_range(0, 15) == 0) hold[m][0] = 0;
                if (hold[m][1] && $urandom_range(0, 15) == 0) hold[m][1] = 0;
                if (!hold[m][0]) begin
                    hold[m][0]   = ($urandom_range(0, 1) == 1);
                    cpu_req[m]   = hold[m][0];
                    cpu_we[m]    = $urandom_range(0, 1) == 1;
                    cpu_addr[m]  = $urandom;
                    cpu_wdata[m] = $urandom;
                end
                if (!hold[m][1]) begin
                    hold[m][1]   = ($urandom_range(0, 1) == 1);
                    ext_req[m]   = hold[m][1];
                    ext_we[m]    = $urandom_range(0, 1) == 1;
                    ext_addr[m]  = $urandom;
                    ext_wdata[m] = $urandom;
                end
                mem_rdata[m] = $urandom;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
